dsp_chain_3_int_sop_3_reduce_accum_8: RTL and testbench

- Downstream consumer of the 8-lane int SOP-3 chain bank.
- Takes the bank's 296-bit result word (8 signed 37-bit lanes) and reduces the 8 lanes through a 3-stage pipelined adder tree.
- Accumulates the per-beat lane sums over a group of beats and presents one wide group result with a valid/ready handshake.
- Feeds the proxy benchmark's result collector.

---
 rtl/dsp_chain_3_int_sop_3_reduce_accum_8.sv | 82 ++++++++
 tb/tb_dsp_chain_3_int_sop_3_reduce_accum_8.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/dsp_chain_3_int_sop_3_reduce_accum_8.sv
// dsp_chain_3_int_sop_3_reduce_accum_8: 8-lane adder-tree reduction followed by a
// grouped accumulator with valid/ready output; the whole pipe freezes on output backpressure.
module dsp_chain_3_int_sop_3_reduce_accum_8 #(
  parameter int LANE_W  = 37,
  parameter int ACC_LEN = 16,
  parameter int ACC_W   = 44,
  parameter int CNT_W   = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [8*LANE_W-1:0] inp,
  input  logic                in_valid,
  input  logic                in_last,
  output logic                in_ready,
  output logic [ACC_W-1:0]    outp,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CNT_W-1:0]    out_beats
);
  logic             stall, fire, close;
  logic [LANE_W-1:0] lane [8];
  logic [LANE_W:0]   s1_d [4], s1_q [4];
  logic [LANE_W+1:0] s2_d [2], s2_q [2];
  logic [LANE_W+2:0] s3_d, s3_q;
  logic [2:0]        v_q, l_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q, beats_d, beats_q;
  logic [ACC_W-1:0]  acc_d, acc_q, outp_d, outp_q, sum_ext, sum;
  logic              ov_d, ov_q;
  assign stall     = ov_q & ~out_ready;
  assign in_ready  = ~stall;
  assign outp      = outp_q;
  assign out_valid = ov_q;
  assign out_beats = beats_q;
  always_comb begin
    for (int i = 0; i < 8; i++) lane[i] = inp[i*LANE_W +: LANE_W];
    for (int i = 0; i < 4; i++)
      s1_d[i] = {lane[2*i][LANE_W-1], lane[2*i]} + {lane[2*i+1][LANE_W-1], lane[2*i+1]};
    for (int i = 0; i < 2; i++)
      s2_d[i] = {s1_q[2*i][LANE_W], s1_q[2*i]} + {s1_q[2*i+1][LANE_W], s1_q[2*i+1]};
    s3_d = {s2_q[0][LANE_W+1], s2_q[0]} + {s2_q[1][LANE_W+1], s2_q[1]};
  end
  // A group closes on the beat's last flag or when the counter hits the final slot,
  // so in_last on the ACC_LEN-th beat yields exactly one result.
  always_comb begin
    fire    = v_q[2] & ~stall;
    close   = l_q[2] | (cnt_q == CNT_W'(ACC_LEN - 1));
    sum_ext = {{(ACC_W-LANE_W-3){s3_q[LANE_W+2]}}, s3_q};
    sum     = ((cnt_q == '0) ? '0 : acc_q) + sum_ext;
    acc_d   = fire ? (close ? '0 : sum) : acc_q;
    cnt_d   = fire ? (close ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
    outp_d  = (fire & close) ? sum : outp_q;
    beats_d = (fire & close) ? cnt_q + CNT_W'(1) : beats_q;
    ov_d    = (fire & close) ? 1'b1 : (out_ready ? 1'b0 : ov_q);
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) s1_q[i] <= '0;
      for (int i = 0; i < 2; i++) s2_q[i] <= '0;
      s3_q    <= '0;
      v_q     <= '0;
      l_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      outp_q  <= '0;
      beats_q <= '0;
      ov_q    <= 1'b0;
    end else begin
      if (!stall) begin
        for (int i = 0; i < 4; i++) s1_q[i] <= s1_d[i];
        for (int i = 0; i < 2; i++) s2_q[i] <= s2_d[i];
        s3_q <= s3_d;
        v_q  <= {v_q[1:0], in_valid};
        l_q  <= {l_q[1:0], in_last};
      end
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      outp_q  <= outp_d;
      beats_q <= beats_d;
      ov_q    <= ov_d;
    end
  end
endmodule

// File: tb/tb_dsp_chain_3_int_sop_3_reduce_accum_8.sv
// tb_dsp_chain_3_int_sop_3_reduce_accum_8: directed and random beats checked against
// a group-sum scoreboard built from accepted beats.
module tb_dsp_chain_3_int_sop_3_reduce_accum_8;
  logic         clk, reset, in_valid, in_last, in_ready, out_valid, out_ready;
  logic [295:0] inp;
  logic [43:0]  outp;
  logic [4:0]   out_beats;
  dsp_chain_3_int_sop_3_reduce_accum_8 dut (
    .clk(clk), .reset(reset), .inp(inp), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .outp(outp), .out_valid(out_valid), .out_ready(out_ready),
    .out_beats(out_beats)
  );
  typedef struct {longint s; int n;} res_t;
  res_t   q[$];
  int     total = 0, bad = 0, n_out = 0, last_beats = 0, m_cnt = 0;
  longint m_sum = 0, last_outp = 0;
  logic   rand_mode = 1'b0, force_ready = 1'b1;
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic check(input string tag, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  function automatic logic [295:0] all_lanes(input logic [36:0] v);
    return {8{v}};
  endfunction
  function automatic longint beat_sum(input logic [295:0] d);
    longint s = 0;
    logic signed [36:0] l;
    for (int i = 0; i < 8; i++) begin
      l = d[i*37 +: 37];
      s += l;
    end
    return s;
  endfunction
  // Scoreboard: group sums from accepted beats; results checked in order on handshake
  always @(negedge clk) begin
    if (!reset) begin
      m_sum = 0;
      m_cnt = 0;
      q.delete();
    end else begin
      if (in_valid && in_ready) begin
        m_sum += beat_sum(inp);
        m_cnt++;
        if (in_last || m_cnt == 16) begin
          q.push_back('{m_sum, m_cnt});
          m_sum = 0;
          m_cnt = 0;
        end
      end
      if (out_valid && out_ready) begin
        last_outp  = longint'($signed(outp));
        last_beats = int'(out_beats);
        n_out++;
        if (q.size() == 0) check("spurious_out", 1, 0);
        else begin
          check("sb_outp", last_outp, q[0].s);
          check("sb_beats", last_beats, q[0].n);
          void'(q.pop_front());
        end
      end
    end
  end
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1 out_ready = rand_mode ? 1'($urandom_range(1)) : force_ready;
    end
  end
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic beat(input logic [295:0] d, input logic last);
    int   t = 0;
    logic ok;
    inp = d;
    in_valid = 1'b1;
    in_last = last;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      t++;
    end while (!ok && t < 2000);
    if (!ok) check("beat_timeout", 0, 1);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
  initial begin
    int     n0, t;
    longint hold_v;
    logic [295:0] d;
    reset = 1'b0;
    in_valid = 1'b0;
    in_last = 1'b0;
    inp = '0;
    idle(2);
    check("rst_outp", longint'(outp), 0);
    check("rst_ovalid", longint'(out_valid), 0);
    check("rst_beats", longint'(out_beats), 0);
    check("rst_iready", longint'(in_ready), 1);
    reset = 1'b1;
    idle(2);
    // 16 beats of ones with exact output latency
    n0 = n_out;
    for (int i = 0; i < 16; i++) beat(all_lanes(37'd1), 1'b0);
    idle(1); check("lat_n1", longint'(out_valid), 0);
    idle(1); check("lat_n2", longint'(out_valid), 0);
    idle(1); check("lat_n3", longint'(out_valid), 1);
    check("t1_outp", longint'($signed(outp)), 128);
    check("t1_beats", longint'(out_beats), 16);
    idle(1); check("t1_pulse", longint'(out_valid), 0);
    check("t1_count", n_out - n0, 1);
    // most negative lanes
    for (int i = 0; i < 16; i++) beat(all_lanes(37'h10_0000_0000), 1'b0);
    idle(5);
    check("t2_outp", last_outp, -64'sd8796093022208);
    check("t2_beats", last_beats, 16);
    // early close then a full group
    for (int k = 1; k <= 3; k++) beat(all_lanes(37'(k)), k == 3);
    idle(5);
    check("t3_outp", last_outp, 48);
    check("t3_beats", last_beats, 3);
    for (int i = 0; i < 16; i++) beat(all_lanes(37'd2), 1'b0);
    idle(5);
    check("t3b_outp", last_outp, 256);
    check("t3b_beats", last_beats, 16);
    // backpressure across three short groups
    n0 = n_out;
    force_ready = 1'b0;
    idle(1);
    fork
      for (int g = 0; g < 3; g++) begin
        beat(all_lanes(37'd1), 1'b0);
        beat(all_lanes(37'd1), 1'b1);
      end
      begin
        t = 0;
        while (!out_valid && t < 200) begin
          @(negedge clk);
          t++;
        end
        check("stall_seen", longint'(out_valid), 1);
        check("stall_iready", longint'(in_ready), 0);
        hold_v = longint'($signed(outp));
        repeat (10) @(negedge clk);
        check("stall_hold", longint'($signed(outp)), hold_v);
        check("stall_ovalid", longint'(out_valid), 1);
        force_ready = 1'b1;
      end
    join
    idle(12);
    check("stall_count", n_out - n0, 3);
    check("stall_outp", last_outp, 16);
    // bubbles between beats
    for (int i = 0; i < 16; i++) begin
      beat(all_lanes(37'd1), 1'b0);
      idle(1);
    end
    idle(4);
    check("bub_outp", last_outp, 128);
    check("bub_beats", last_beats, 16);
    // reset mid-group
    for (int i = 0; i < 5; i++) beat(all_lanes(37'd3), 1'b0);
    reset = 1'b0;
    idle(1);
    check("mrst_ovalid", longint'(out_valid), 0);
    check("mrst_iready", longint'(in_ready), 1);
    idle(2);
    reset = 1'b1;
    n0 = n_out;
    for (int i = 0; i < 16; i++) beat(all_lanes(37'd1), 1'b0);
    idle(6);
    check("mrst_count", n_out - n0, 1);
    check("mrst_outp", last_outp, 128);
    // random traffic with random backpressure
    rand_mode = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      else begin
        for (int j = 0; j < 8; j++) d[j*37 +: 37] = 37'({$urandom(), $urandom()});
        beat(d, $urandom_range(7) == 0);
      end
    end
    rand_mode = 1'b0;
    force_ready = 1'b1;
    idle(30);
    check("drain_empty", q.size(), 0);
    check("drain_partial", m_cnt >= 0 && m_cnt < 16, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
